// File: rtl/input_datapath.sv
// input_datapath
//   Receive-side deserializer for the systolic array operand load path.
//   Narrow beats arrive from the host/DMA port over a valid/ready handshake.
//   They are packed LSB-first into one full-width word. The word is then
//   held and presented to the array side until that side accepts it.
//
// Ports
//   clk         clock; all logic on posedge
//   reset       synchronous, active-high reset
//   src_valid   source presents a beat on data_in
//   data_in     incoming beat (BEAT_WIDTH)
//   src_ready   block accepts a beat this cycle (COLLECT state)
//   dest_ready  array side accepts the assembled word
//   dest_valid  word_out holds a complete word (HOLD state)
//   word_out    assembled word (WORD_WIDTH)
//   beat_count  beats captured into the current word
//   rx_done     one-cycle pulse after the last beat of a word is accepted
//   tx_done     one-cycle pulse after the word handoff completes
module input_datapath #(
    parameter  int BEAT_WIDTH = 64,
    parameter  int WORD_WIDTH = 512,
    localparam int NUM_BEATS  = WORD_WIDTH / BEAT_WIDTH,
    localparam int CNT_WIDTH  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  src_valid,
    input  logic [BEAT_WIDTH-1:0] data_in,
    output logic                  src_ready,
    input  logic                  dest_ready,
    output logic                  dest_valid,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic                  rx_done,
    output logic                  tx_done
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(NUM_BEATS - 1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
    logic [WORD_WIDTH-1:0] buf_q,   buf_d;
    logic                  rx_q,    rx_d;
    logic                  tx_q,    tx_d;

    // Handshake outputs come only from registered state, so there is no
    // combinational path from src_valid/dest_ready to any output.
    assign src_ready  = (state_q == COLLECT);
    assign dest_valid = (state_q == HOLD);
    assign word_out   = buf_q;
    assign beat_count = cnt_q;
    assign rx_done    = rx_q;
    assign tx_done    = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        rx_d    = 1'b0;
        tx_d    = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (src_valid) begin
                    // The buffer is never cleared between words: every slot
                    // is rewritten before the next HOLD, so stale data from a
                    // previous word cannot leak into a completed one.
                    for (int i = 0; i < NUM_BEATS; i++) begin
                        if (cnt_q == CNT_WIDTH'(i)) begin
                            buf_d[i*BEAT_WIDTH +: BEAT_WIDTH] = data_in;
                        end
                    end
                    if (cnt_q == LAST_SLOT) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                        rx_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            HOLD: begin
                // Incoming beats are ignored here; src_ready is low.
                if (dest_ready) begin
                    state_d = COLLECT;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            buf_q   <= '0;
            rx_q    <= 1'b0;
            tx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_input_datapath.sv
module tb_input_datapath;
    localparam int BW = 64;
    localparam int WW = 512;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          src_valid;
    logic [BW-1:0] data_in;
    logic          src_ready;
    logic          dest_ready;
    logic          dest_valid;
    logic [WW-1:0] word_out;
    logic [2:0]    beat_count;
    logic          rx_done;
    logic          tx_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;
    int n_hand = 0;

    // Scoreboard: expected words pushed when their last beat is driven,
    // popped and compared at the handoff.
    logic [WW-1:0] exp_q[$];

    // Reference model of the protocol
    logic [WW-1:0] m_word;
    bit            m_hold;
    int            m_cnt;

    always #5 clk = ~clk;

    input_datapath #(.BEAT_WIDTH(BW), .WORD_WIDTH(WW)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_valid  (src_valid),
        .data_in    (data_in),
        .src_ready  (src_ready),
        .dest_ready (dest_ready),
        .dest_valid (dest_valid),
        .word_out   (word_out),
        .beat_count (beat_count),
        .rx_done    (rx_done),
        .tx_done    (tx_done)
    );

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // One clock cycle: drive inputs, predict, advance, check all outputs.
    task automatic cycle(input bit v, input logic [BW-1:0] d, input bit dr, output bit acc);
        bit            hand;
        bit            last;
        logic [WW-1:0] e;
        src_valid  = v;
        data_in    = d;
        dest_ready = dr;
        acc  = v && !m_hold;
        hand = dr && m_hold;
        last = acc && (m_cnt == NB - 1);
        if (hand) begin
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL sb_underflow: observed handoff with %0d queued, expected >0", exp_q.size());
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("word_handoff", word_out, e);
            end
            n_hand++;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (acc) m_word[m_cnt*BW +: BW] = d;
        if (last) begin
            exp_q.push_back(m_word);
            m_hold = 1'b1;
            m_cnt  = 0;
        end else if (acc) begin
            m_cnt++;
        end
        if (hand) m_hold = 1'b0;
        chk("rx_done",    WW'(rx_done),    WW'(last));
        chk("tx_done",    WW'(tx_done),    WW'(hand));
        chk("beat_count", WW'(beat_count), WW'(m_cnt[2:0]));
        chk("src_ready",  WW'(src_ready),  WW'(!m_hold));
        chk("dest_valid", WW'(dest_valid), WW'(m_hold));
        if (m_hold && exp_q.size() > 0) chk("word_hold", word_out, exp_q[0]);
    endtask

    task automatic rst_cycle(input bit dr);
        reset      = 1'b1;
        dest_ready = dr;
        src_valid  = 1'b1;
        data_in    = '1;
        @(posedge clk);
        #1;
        cyc_n++;
        m_hold = 1'b0;
        m_cnt  = 0;
        m_word = '0;
        exp_q.delete();
        chk("rst_rx_done",    WW'(rx_done),    WW'(1'b0));
        chk("rst_tx_done",    WW'(tx_done),    WW'(1'b0));
        chk("rst_dest_valid", WW'(dest_valid), WW'(1'b0));
        chk("rst_src_ready",  WW'(src_ready),  WW'(1'b1));
        chk("rst_beat_count", WW'(beat_count), WW'(3'd0));
        chk("rst_word_out",   word_out,        WW'(0));
        reset     = 1'b0;
        src_valid = 1'b0;
    endtask

    function automatic logic [BW-1:0] pat(input int w, input int b);
        case (w % 3)
            0:       pat = {56'hA5A5A5A5A5A5A5, 8'(b)};
            1:       pat = {56'h5A5A5A5A5A5A5A, 8'(b)};
            default: pat = BW'(w * 16 + b + 1);
        endcase
    endfunction

    initial begin
        bit            acc;
        logic [WW-1:0] w1_exp;
        int            h0;
        int            wi;
        int            bi;
        int            last_rx;

        reset      = 1'b1;
        src_valid  = 1'b0;
        dest_ready = 1'b0;
        data_in    = '0;
        m_word     = '0;
        m_hold     = 1'b0;
        m_cnt      = 0;
        rst_cycle(1'b0);
        rst_cycle(1'b0);

        // Eight back-to-back beats, array side not ready
        for (int k = 1; k <= NB; k++) cycle(1'b1, BW'(k), 1'b0, acc);
        w1_exp = {64'd8, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1};
        chk("w1_const", word_out, w1_exp);
        chk("w1_src_ready", WW'(src_ready), WW'(1'b0));

        // Backpressure: 20 cycles in HOLD with beats presented, then handoff
        for (int k = 0; k < 20; k++) cycle(1'b1, 64'hDEAD_BEEF_0000_0000 | BW'(k), 1'b0, acc);
        chk("w1_stable", word_out, w1_exp);
        cycle(1'b1, 64'hDEAD_0000_0000_0001, 1'b1, acc);
        cycle(1'b0, '0, 1'b1, acc);

        // Random source gaps across three words
        h0 = n_hand;
        wi = 0;
        bi = 0;
        for (int k = 0; k < 300 && (n_hand - h0) < 3; k++) begin
            cycle(bit'($urandom_range(0, 1)), pat(wi, bi), 1'b1, acc);
            if (acc) begin
                bi++;
                if (bi == NB) begin
                    bi = 0;
                    wi++;
                end
            end
        end
        chk("rand_words", WW'(n_hand - h0), WW'(3));

        // Continuous streaming: one word every NB+1 cycles
        last_rx = -1;
        for (int k = 0; k < 40; k++) begin
            cycle(1'b1, {32'hC0DE_0000, 32'(k)}, 1'b1, acc);
            if (rx_done) begin
                if (last_rx >= 0) chk("stream_period", WW'(cyc_n - last_rx), WW'(NB + 1));
                last_rx = cyc_n;
            end
        end

        // Reset after five beats, then a clean word
        rst_cycle(1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b1, 64'hBAD0_0000_0000_0000 | BW'(k), 1'b0, acc);
        rst_cycle(1'b0);
        for (int k = 0; k < NB + 1; k++) cycle(1'b1, 64'h1234_0000_0000_0000 | BW'(k), 1'b1, acc);
        chk("abort_sb_empty", WW'(exp_q.size()), WW'(0));

        // Reset in HOLD with dest_ready high in the same cycle
        for (int k = 0; k < NB; k++) cycle(1'b1, 64'h7777_0000_0000_0000 | BW'(k), 1'b0, acc);
        chk("pre_rst_hold", WW'(dest_valid), WW'(1'b1));
        rst_cycle(1'b1);
        cycle(1'b0, '0, 1'b0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
